// File: rtl/demux_1xn_stripe.sv
// ============================================================================
// Module   : demux_1xn_stripe
// Summary  : 1-to-LANES demux with registered lanes and per-lane valid/ready.
//            Defining DEMUX_PARITY_EN adds the registered out_parity port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_1xn_stripe #(
    parameter int BW    = 8,
    parameter int LANES = 2,
    parameter int SELW  = $clog2(LANES)
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [BW-1:0]         data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    output logic [LANES*BW-1:0]   data_out,
    output logic [LANES-1:0]      valid_out,
    input  logic [LANES-1:0]      ready_out,
    output logic [SELW-1:0]       lane_ptr,
    output logic                  err_out
`ifdef DEMUX_PARITY_EN
    ,
    output logic [LANES-1:0]      out_parity
`endif
);

    localparam logic [SELW-1:0] C_LAST_LANE = SELW'(LANES - 1);

    logic [LANES-1:0][BW-1:0] data_q,  data_d;
    logic [LANES-1:0]         valid_q, valid_d;
    logic [SELW-1:0]          ptr_q,   ptr_d;
    logic                     err_q,   err_d;
`ifdef DEMUX_PARITY_EN
    logic [LANES-1:0]         par_q,   par_d;
`endif

    logic [SELW-1:0]  w_tgt;
    logic             w_tgt_ok;
    logic [LANES-1:0] w_free;
    logic [LANES-1:0] w_load;
    logic             w_ready;
    logic             w_accept;

    assign w_tgt    = mode ? sel : ptr_q;
    assign w_tgt_ok = ({{(32-SELW){1'b0}}, w_tgt} < 32'(LANES));
    assign w_free   = ~valid_q | ready_out;

    // A word aimed at a nonexistent lane is always accepted so it can be dropped.
    always_comb begin
        w_ready = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (w_tgt == SELW'(i)) begin
                w_ready = w_free[i];
            end
        end
    end

    assign w_accept = valid_in & w_ready;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < LANES; i++) begin
            w_load[i] = w_accept & w_tgt_ok & (w_tgt == SELW'(i));
        end
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        err_d   = err_q;
`ifdef DEMUX_PARITY_EN
        par_d   = par_q;
`endif
        for (int i = 0; i < LANES; i++) begin
            if (w_load[i]) begin
                data_d[i]  = data_in;
                valid_d[i] = 1'b1;
`ifdef DEMUX_PARITY_EN
                par_d[i]   = ^data_in;
`endif
            end else if (ready_out[i]) begin
                valid_d[i] = 1'b0;
            end
        end
        if (w_accept && !mode) begin
            ptr_d = (ptr_q == C_LAST_LANE) ? '0 : ptr_q + SELW'(1);
        end
        if (w_accept && !w_tgt_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_q  <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
`ifdef DEMUX_PARITY_EN
            par_q   <= '0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
`ifdef DEMUX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign ready_in  = w_ready;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign lane_ptr  = ptr_q;
    assign err_out   = err_q;
`ifdef DEMUX_PARITY_EN
    assign out_parity = par_q;
`endif

endmodule

`default_nettype wire
